// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC and issues req/ack memory fetches into a single IF/ID output slot, with redirect squash and a one-entry skid.
// Latency: the instruction appears on inst_o/pc_o one cycle after mem_ack_i; zero-wait memory sustains one instruction per cycle.
// Backpressure: stall_i holds the output slot, a returning word parks in the skid and requests pause until the slot drains.
// Optional macro IF_MISALIGN_TRAP_EN: a misaligned redirect target raises sticky misalign_o and halts fetch.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_i,
    input  logic              b_flag_i,
    input  logic [ADDR_W-1:0] b_target_addr_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ack_i,
    input  logic [31:0]       mem_data_i,
`ifdef IF_MISALIGN_TRAP_EN
    output logic              misalign_o,
`endif
    output logic              inst_valid_o,
    output logic [31:0]       inst_o,
    output logic [ADDR_W-1:0] pc_o
);

    typedef enum logic [1:0] {IDLE, REQ, SKID} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] fetch_pc_q;
    logic              mem_req_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              inst_valid_q;
    logic [31:0]       inst_q;
    logic [ADDR_W-1:0] pc_q;
    logic              skid_vld_q;
    logic [31:0]       skid_dat_q;
    logic              discard_q;
`ifdef IF_MISALIGN_TRAP_EN
    logic              misalign_q;
`endif

    logic [ADDR_W-1:0] fetch_pc_inc_d;
    logic [ADDR_W-1:0] target_d;
    logic              slot_free_d;

    // Next sequential PC (wraps naturally), word-aligned redirect target, and output slot availability.
    always_comb begin
        fetch_pc_inc_d = fetch_pc_q + ADDR_W'(4);
        target_d       = {b_target_addr_i[ADDR_W-1:2], 2'b00};
        slot_free_d    = !inst_valid_q || !stall_i;
    end

    // Fetch FSM: request sequencing, squash on redirect, output slot and skid management.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            fetch_pc_q   <= ADDR_W'(RESET_PC);
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            inst_valid_q <= 1'b0;
            inst_q       <= '0;
            pc_q         <= '0;
            skid_vld_q   <= 1'b0;
            skid_dat_q   <= '0;
            discard_q    <= 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
            misalign_q   <= 1'b0;
`endif
        end else begin
            // A consumed slot empties unless a branch below refills it.
            if (inst_valid_q && !stall_i) begin
                inst_valid_q <= 1'b0;
            end
`ifdef IF_MISALIGN_TRAP_EN
            if (misalign_q) begin
                // Halted after a misaligned redirect: nothing more is fetched until reset.
                state_q      <= IDLE;
                mem_req_q    <= 1'b0;
                inst_valid_q <= 1'b0;
            end else if (b_flag_i && (b_target_addr_i[1:0] != 2'b00)) begin
                misalign_q   <= 1'b1;
                inst_valid_q <= 1'b0;
                skid_vld_q   <= 1'b0;
                mem_req_q    <= 1'b0;
                discard_q    <= 1'b0;
                state_q      <= IDLE;
            end else
`endif
            if (b_flag_i) begin
                inst_valid_q <= 1'b0;
                skid_vld_q   <= 1'b0;
                fetch_pc_q   <= target_d;
                if (state_q == REQ && !mem_ack_i) begin
                    // Keep the in-flight address stable; its data is dropped when it returns.
                    discard_q <= 1'b1;
                end else begin
                    discard_q  <= 1'b0;
                    mem_req_q  <= 1'b1;
                    mem_addr_q <= target_d;
                    state_q    <= REQ;
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= fetch_pc_q;
                        state_q    <= REQ;
                    end
                    REQ: begin
                        if (mem_ack_i) begin
                            if (discard_q) begin
                                discard_q  <= 1'b0;
                                mem_addr_q <= fetch_pc_q;
                            end else if (slot_free_d) begin
                                inst_q       <= mem_data_i;
                                pc_q         <= mem_addr_q;
                                inst_valid_q <= 1'b1;
                                fetch_pc_q   <= fetch_pc_inc_d;
                                mem_addr_q   <= fetch_pc_inc_d;
                            end else begin
                                skid_dat_q <= mem_data_i;
                                skid_vld_q <= 1'b1;
                                mem_req_q  <= 1'b0;
                                state_q    <= SKID;
                            end
                        end
                    end
                    SKID: begin
                        // fetch_pc still names the parked word until it moves to the slot.
                        if (!stall_i) begin
                            inst_q       <= skid_dat_q;
                            pc_q         <= fetch_pc_q;
                            inst_valid_q <= 1'b1;
                            skid_vld_q   <= 1'b0;
                            fetch_pc_q   <= fetch_pc_inc_d;
                            mem_addr_q   <= fetch_pc_inc_d;
                            mem_req_q    <= 1'b1;
                            state_q      <= REQ;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign mem_req_o    = mem_req_q;
    assign mem_addr_o   = mem_addr_q;
    assign inst_valid_o = inst_valid_q;
    assign inst_o       = inst_q;
    assign pc_o         = pc_q;
`ifdef IF_MISALIGN_TRAP_EN
    assign misalign_o   = misalign_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: streaming fetch, stall/skid, redirect squash, stray ack, alignment, async reset.
// Memory model is combinational: it acks in the same cycle as the request while mem_rdy is high.
// Outputs are sampled 1 time unit after the rising edge.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i;
    logic        b_flag_i;
    logic [31:0] b_target_addr_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_data_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
`ifdef IF_MISALIGN_TRAP_EN
    logic        misalign_o;
`endif

    logic mem_rdy;
    logic stray;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] dat(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    assign mem_ack_i  = (mem_req_o && mem_rdy) || stray;
    assign mem_data_i = stray ? 32'hDEAD_BEEF : dat(mem_addr_o);

    if_fetch_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall_i         (stall_i),
        .b_flag_i        (b_flag_i),
        .b_target_addr_i (b_target_addr_i),
        .mem_req_o       (mem_req_o),
        .mem_addr_o      (mem_addr_o),
        .mem_ack_i       (mem_ack_i),
        .mem_data_i      (mem_data_i),
`ifdef IF_MISALIGN_TRAP_EN
        .misalign_o      (misalign_o),
`endif
        .inst_valid_o    (inst_valid_o),
        .inst_o          (inst_o),
        .pc_o            (pc_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_req(input string tag, input logic req, input logic [31:0] addr);
        chk({tag, ".req"}, {31'd0, mem_req_o}, {31'd0, req});
        if (req) chk({tag, ".addr"}, mem_addr_o, addr);
    endtask

    task automatic exp_slot(input string tag, input logic v, input logic [31:0] pc);
        chk({tag, ".valid"}, {31'd0, inst_valid_o}, {31'd0, v});
        if (v) begin
            chk({tag, ".pc"}, pc_o, pc);
            chk({tag, ".inst"}, inst_o, dat(pc));
        end
    endtask

    initial begin
        rst_n = 1'b0; stall_i = 1'b0; b_flag_i = 1'b0; b_target_addr_i = '0;
        mem_rdy = 1'b1; stray = 1'b0;

        // Reset values
        tick();
        chk("rst.req", {31'd0, mem_req_o}, 32'd0);
        chk("rst.addr", mem_addr_o, 32'h0);
        chk("rst.valid", {31'd0, inst_valid_o}, 32'd0);
        chk("rst.inst", inst_o, 32'h0);
        chk("rst.pc", pc_o, 32'h0);
        rst_n = 1'b1;

        // Streaming at zero-wait memory
        tick(); exp_req("c1", 1'b1, 32'h0); exp_slot("c1", 1'b0, 32'h0);
        tick(); exp_req("c2", 1'b1, 32'h4); exp_slot("c2", 1'b1, 32'h0);
        tick(); exp_req("c3", 1'b1, 32'h8); exp_slot("c3", 1'b1, 32'h4);
        tick(); exp_req("c4", 1'b1, 32'hC); exp_slot("c4", 1'b1, 32'h8);

        // Stall 3 cycles: word at 0xC parks in skid, slot holds 0x8
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); exp_req("stall", 1'b0, 32'h0); exp_slot("stall", 1'b1, 32'h8);
        end
        stall_i = 1'b0;
        tick(); exp_req("unstall1", 1'b1, 32'h10); exp_slot("unstall1", 1'b1, 32'hC);
        tick(); exp_req("unstall2", 1'b1, 32'h14); exp_slot("unstall2", 1'b1, 32'h10);

        // Redirect with an outstanding request at 0x14, ack two cycles later
        mem_rdy = 1'b0;
        tick(); exp_req("wait", 1'b1, 32'h14); exp_slot("wait", 1'b0, 32'h0);
        b_flag_i = 1'b1; b_target_addr_i = 32'h100;
        tick(); b_flag_i = 1'b0;
        exp_req("disc1", 1'b1, 32'h14); exp_slot("disc1", 1'b0, 32'h0);
        tick(); exp_req("disc2", 1'b1, 32'h14); exp_slot("disc2", 1'b0, 32'h0);
        mem_rdy = 1'b1;
        tick(); exp_req("drop", 1'b1, 32'h100); exp_slot("drop", 1'b0, 32'h0);
        tick(); exp_req("tgt", 1'b1, 32'h104); exp_slot("tgt", 1'b1, 32'h100);

        // Redirect coinciding with ack of 0x104, target 0x40
        b_flag_i = 1'b1; b_target_addr_i = 32'h40;
        tick(); b_flag_i = 1'b0;
        exp_req("coin1", 1'b1, 32'h40); exp_slot("coin1", 1'b0, 32'h0);
        tick(); exp_req("coin2", 1'b1, 32'h44); exp_slot("coin2", 1'b1, 32'h40);

        // Stray ack while in SKID (mem_req_o=0) must not disturb the parked word
        stall_i = 1'b1;
        tick(); exp_req("skid", 1'b0, 32'h0); exp_slot("skid", 1'b1, 32'h40);
        stray = 1'b1;
        tick(); stray = 1'b0;
        exp_req("stray", 1'b0, 32'h0); exp_slot("stray", 1'b1, 32'h40);
        stall_i = 1'b0;
        tick(); exp_req("post1", 1'b1, 32'h48); exp_slot("post1", 1'b1, 32'h44);
        tick(); exp_req("post2", 1'b1, 32'h4C); exp_slot("post2", 1'b1, 32'h48);

        // Misaligned redirect target 0x102
        b_flag_i = 1'b1; b_target_addr_i = 32'h102;
        tick(); b_flag_i = 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
        for (int i = 0; i < 3; i++) begin
            chk("mis.flag", {31'd0, misalign_o}, 32'd1);
            exp_req("mis", 1'b0, 32'h0); exp_slot("mis", 1'b0, 32'h0);
            tick();
        end
`else
        exp_req("mask1", 1'b1, 32'h100); exp_slot("mask1", 1'b0, 32'h0);
        tick(); exp_req("mask2", 1'b1, 32'h104); exp_slot("mask2", 1'b1, 32'h100);
        mem_rdy = 1'b0;
        tick(); exp_req("hold", 1'b1, 32'h104); exp_slot("hold", 1'b0, 32'h0);
`endif

        // Asynchronous reset in mid-cycle
        #2 rst_n = 1'b0;
        #1;
        chk("arst.req", {31'd0, mem_req_o}, 32'd0);
        chk("arst.addr", mem_addr_o, 32'h0);
        chk("arst.valid", {31'd0, inst_valid_o}, 32'd0);
        chk("arst.inst", inst_o, 32'h0);
        chk("arst.pc", pc_o, 32'h0);
`ifdef IF_MISALIGN_TRAP_EN
        chk("arst.mis", {31'd0, misalign_o}, 32'd0);
`endif
        tick();
        rst_n = 1'b1; mem_rdy = 1'b1;
        tick(); exp_req("rel1", 1'b1, 32'h0); exp_slot("rel1", 1'b0, 32'h0);
        tick(); exp_req("rel2", 1'b1, 32'h4); exp_slot("rel2", 1'b1, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
